// File: rtl/imm_gen_arbiter_if.sv
// Request/result bundle between the two ID decode lanes, the shared immediate
// extender and the rename/dispatch consumer.
interface imm_gen_arbiter_if #(
  parameter int unsigned IMM_WIDTH                 = 12,
  parameter int unsigned GENERATED_IMMEDIATE_WIDTH = 32,
  parameter int unsigned TAG_WIDTH                 = 6
);
  logic                                 req0_valid;
  logic                                 req0_ready;
  logic [IMM_WIDTH-1:0]                 req0_imm;
  logic                                 req0_zext;
  logic [TAG_WIDTH-1:0]                 req0_tag;

  logic                                 req1_valid;
  logic                                 req1_ready;
  logic [IMM_WIDTH-1:0]                 req1_imm;
  logic                                 req1_zext;
  logic [TAG_WIDTH-1:0]                 req1_tag;

  logic                                 out_valid;
  logic                                 out_ready;
  logic [GENERATED_IMMEDIATE_WIDTH-1:0] out_imm;
  logic [TAG_WIDTH-1:0]                 out_tag;
  logic                                 out_lane;

  // Driver side: decode lanes plus the downstream consumer.
  modport master (
    output req0_valid, req0_imm, req0_zext, req0_tag,
    output req1_valid, req1_imm, req1_zext, req1_tag,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_imm, out_tag, out_lane
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_imm, req0_zext, req0_tag,
    input  req1_valid, req1_imm, req1_zext, req1_tag,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_imm, out_tag, out_lane
  );
endinterface

// File: rtl/imm_gen_arbiter.sv
// Round-robin shared immediate extender for two decode lanes with a single
// registered valid/ready output stage and pipeline flush.
module imm_gen_arbiter #(
  parameter int unsigned IMM_WIDTH                 = 12,
  parameter int unsigned GENERATED_IMMEDIATE_WIDTH = 32,
  parameter int unsigned TAG_WIDTH                 = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  imm_gen_arbiter_if.slave        bus
);

  localparam int unsigned ExtWidth = GENERATED_IMMEDIATE_WIDTH - IMM_WIDTH;

  if (GENERATED_IMMEDIATE_WIDTH <= IMM_WIDTH) begin : g_bad_width
    $error("imm_gen_arbiter: GENERATED_IMMEDIATE_WIDTH must exceed IMM_WIDTH");
  end

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e                               state_q;
  logic                                 last_grant_q;
  logic                                 out_valid_q;
  logic [GENERATED_IMMEDIATE_WIDTH-1:0] out_imm_q;
  logic [TAG_WIDTH-1:0]                 out_tag_q;
  logic                                 out_lane_q;

  logic                                 can_accept;
  logic                                 grant1;
  logic                                 accept;
  logic [IMM_WIDTH-1:0]                 sel_imm;
  logic                                 sel_zext;
  logic [TAG_WIDTH-1:0]                 sel_tag;
  logic [GENERATED_IMMEDIATE_WIDTH-1:0] ext_imm;

  // Lane 1 wins when it is alone or when lane 0 was served last; reset_n gating
  // keeps both readies low for as long as reset is held.
  always_comb begin
    can_accept     = reset_n && !flush && ((state_q == StEmpty) || bus.out_ready);
    grant1         = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    bus.req0_ready = can_accept && bus.req0_valid && !grant1;
    bus.req1_ready = can_accept && grant1;
    accept         = can_accept && (bus.req0_valid || bus.req1_valid);
  end

  always_comb begin
    sel_imm  = grant1 ? bus.req1_imm  : bus.req0_imm;
    sel_zext = grant1 ? bus.req1_zext : bus.req0_zext;
    sel_tag  = grant1 ? bus.req1_tag  : bus.req0_tag;
    if (sel_zext) begin
      ext_imm = {{ExtWidth{1'b0}}, sel_imm};
    end else begin
      ext_imm = {{ExtWidth{sel_imm[IMM_WIDTH-1]}}, sel_imm};
    end
  end

  // accept already implies EMPTY or a draining FULL, so fill has priority
  // over the plain drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StEmpty;
      last_grant_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      out_lane_q   <= 1'b0;
    end else if (flush) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_q      <= StFull;
            out_valid_q  <= 1'b1;
            out_imm_q    <= ext_imm;
            out_tag_q    <= sel_tag;
            out_lane_q   <= grant1;
            last_grant_q <= grant1;
          end
        end
        StFull: begin
          if (accept) begin
            out_valid_q  <= 1'b1;
            out_imm_q    <= ext_imm;
            out_tag_q    <= sel_tag;
            out_lane_q   <= grant1;
            last_grant_q <= grant1;
          end else if (bus.out_ready) begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StEmpty;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_lane  = out_lane_q;

  // Stall seen at the previous edge; cleared asynchronously so a mid-cycle
  // reset does not look like a data change under backpressure.
  logic stall_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= bus.out_valid && !bus.out_ready && !flush;
    end
  end

  a_out_stable: assert property (@(posedge clk) disable iff (!reset_n)
    stall_q |-> ($stable(bus.out_imm) && $stable(bus.out_tag) && $stable(bus.out_lane)));

  a_ready_mutex: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.req0_ready && bus.req1_ready));

endmodule

// File: doc/imm_gen_arbiter.md
Name: imm_gen_arbiter

Overview:
- Shares one immediate-extension datapath between the two decode lanes of the ID stage.
- Round-robin arbitration between lane requests; the granted lane's raw immediate is sign- or zero-extended to register width.
- Result, tag and source lane are registered into a single output stage with a valid/ready handshake toward rename/dispatch.
- Supports pipeline flush for branch mispredict and exception recovery.

Parameters:
- IMM_WIDTH, `IMM_WIDTH (12): raw immediate width per request.
- GENERATED_IMMEDIATE_WIDTH, `REG_VAL_WIDTH (32): extended result width. Must be > IMM_WIDTH; elaboration error otherwise.
- TAG_WIDTH, 6: instruction tag width, carried unchanged.

Ports:
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous pipeline flush.
- req0_valid, input, 1: lane 0 request valid.
- req0_ready, output, 1: lane 0 request accepted this cycle.
- req0_imm, input, IMM_WIDTH: lane 0 raw immediate.
- req0_zext, input, 1: lane 0 mode. 1 = zero-extend, 0 = sign-extend.
- req0_tag, input, TAG_WIDTH: lane 0 instruction tag.
- req1_valid, req1_ready, req1_imm, req1_zext, req1_tag: same as lane 0, for lane 1.
- out_valid, output, 1: output stage holds a result.
- out_ready, input, 1: consumer accepts the result.
- out_imm, output, GENERATED_IMMEDIATE_WIDTH: extended immediate.
- out_tag, output, TAG_WIDTH: tag of the result.
- out_lane, output, 1: source lane of the result.

Behaviour:
- Reset (reset_n low, asynchronous):
  - out_valid=0, out_imm=0, out_tag=0, out_lane=0.
  - Round-robin pointer last_grant=1, so lane 0 has priority after reset.
  - FSM goes to EMPTY.
  - req*_ready is 0 while reset is asserted.
- FSM states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Capacity: can_accept = !flush && (state==EMPTY || out_ready).
- Grant logic (combinational, same cycle):
  - Only req0_valid: grant lane 0.
  - Only req1_valid: grant lane 1.
  - Both valid: grant the lane != last_grant.
  - reqX_ready = can_accept && grant==X. At most one ready is high per cycle.
  - A ready is never asserted without the matching valid.
- Accept = valid && ready on the granted lane. On accept at edge N:
  - out_* load at N+1 and out_valid=1, giving one-cycle latency.
  - last_grant <= granted lane.
  - FSM goes to FULL.
  - Throughput is one result per cycle when out_ready is held high.
- Extension:
  - Sign-extend: upper GENERATED_IMMEDIATE_WIDTH-IMM_WIDTH bits replicate req_imm[IMM_WIDTH-1].
  - Zero-extend: upper bits are 0.
  - Low IMM_WIDTH bits equal req_imm unchanged.
- Transitions:
  - FULL with out_ready=1 and no accept -> EMPTY.
  - FULL with out_ready=1 and accept -> FULL with the new data. Simultaneous drain and fill is allowed.
  - FULL with out_ready=0 -> FULL. out_imm/out_tag/out_lane are stable, and both ready outputs are 0.
- Flush (wins over all other events):
  - Next edge: out_valid=0, FSM goes to EMPTY. The pending result is discarded even if out_ready=1.
  - No request is accepted in the flush cycle.
  - last_grant is unchanged.
  - Data registers keep their old values (don't-care).
- Lane handshake: a lane holding valid must keep imm/zext/tag stable until accepted. The block does not check this.
- Fairness: with both lanes continuously valid and out_ready=1, grants strictly alternate. No lane waits more than one accept.
- Reset mid-operation: immediate return to reset values. A held result is lost.
- Assertions:
  - Outputs are stable while out_valid && !out_ready.
  - req0_ready && req1_ready never both high.

Test Plan:
- Reset then idle: reset_n low 3 cycles with req0_valid=1 -> req0_ready=0, out_valid=0, out_imm=0. First edge after release: lane 0 accepted, out_valid=1 one cycle later.
- Sign/zero extend: lane0 imm=12'h800, zext=0, tag=5 -> out_imm=32'hFFFF_F800, out_tag=5, out_lane=0. Same imm with zext=1 -> 32'h0000_0800. imm=12'h7FF, zext=0 -> 32'h0000_07FF.
- Round robin: both lanes valid for 6 cycles, out_ready=1 -> out_lane sequence 0,1,0,1,0,1, one result per cycle.
- Backpressure: result held, out_ready=0 for 4 cycles, both lanes valid -> both ready=0, out_* stable. out_ready=1 -> drain and new accept on the same edge, out_valid stays 1.
- Flush: flush with out_valid=1, out_ready=1, req0_valid=1 -> req0_ready=0, out_valid=0 next cycle. Lane 0 accepted the following cycle.
- Reset mid-stall: FULL with out_ready=0, reset_n pulsed low asynchronously mid-cycle -> out_valid=0 immediately. Priority returns to lane 0.
